// File: rtl/multiplier.sv
// Sequential IEEE-754 single-precision multiplier.
// Special operands (NaN, infinity, zero) are resolved on the capture edge.
// Normal operands run a 24-step radix-2 shift-and-add, then are normalized.
// Rounding is truncation toward zero and denormals are flushed to zero.
module multiplier (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_valid_i,
  input  logic        x_sign_i,
  input  logic        y_sign_i,
  input  logic [7:0]  x_exp_i,
  input  logic [7:0]  y_exp_i,
  input  logic [22:0] x_frac_i,
  input  logic [22:0] y_frac_i,
  input  logic        x_infinity_i,
  input  logic        y_infinity_i,
  input  logic        x_nan_i,
  input  logic        y_nan_i,
  output logic        data_valid_o,
  output logic [31:0] z_o,
  output logic        except_invalid_operation_o,
  output logic        except_overflow_o,
  output logic        except_underflow_o
);

  typedef enum logic [1:0] {IDLE, MULTIPLY, NORMALIZE, DONE} state_t;

  state_t             r_state;
  logic               r_sign;
  logic signed [9:0]  r_exp;
  logic [47:0]        r_mcand;
  logic [23:0]        r_mplier;
  logic [47:0]        r_acc;
  logic [4:0]         r_cnt;
  logic [31:0]        r_res_z;
  logic               r_res_inv;
  logic               r_res_ovf;
  logic               r_res_unf;
  logic               r_valid;
  logic [31:0]        r_z;
  logic               r_inv;
  logic               r_ovf;
  logic               r_unf;

  logic               w_sign;
  logic               w_x_zero;
  logic               w_y_zero;
  logic               w_nan;
  logic               w_inf;
  logic               w_zero;
  logic signed [9:0]  w_exp_sum;
  logic signed [9:0]  w_norm_exp;
  logic [22:0]        w_norm_frac;
  logic               w_ovf;
  logic               w_unf;

  // Operand classification and special-case priority (NaN > infinity > zero)
  assign w_sign    = x_sign_i ^ y_sign_i;
  assign w_x_zero  = (x_exp_i == 8'd0);
  assign w_y_zero  = (y_exp_i == 8'd0);
  assign w_nan     = x_nan_i | y_nan_i | (x_infinity_i & w_y_zero) | (y_infinity_i & w_x_zero);
  assign w_inf     = x_infinity_i | y_infinity_i;
  assign w_zero    = w_x_zero | w_y_zero;
  assign w_exp_sum = $signed({2'b00, x_exp_i}) + $signed({2'b00, y_exp_i}) - 10'sd127;

  // Normalization of the finished 48-bit significand product
  assign w_norm_exp  = r_acc[47] ? (r_exp + 10'sd1) : r_exp;
  assign w_norm_frac = r_acc[47] ? r_acc[46:24] : r_acc[45:23];
  assign w_ovf       = (w_norm_exp >= 10'sd255);
  assign w_unf       = (w_norm_exp <= 10'sd0);

  // Control FSM, shift-and-add datapath and registered result outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_sign    <= 1'b0;
      r_exp     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_res_z   <= '0;
      r_res_inv <= 1'b0;
      r_res_ovf <= 1'b0;
      r_res_unf <= 1'b0;
      r_valid   <= 1'b0;
      r_z       <= '0;
      r_inv     <= 1'b0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (data_valid_i) begin
            r_sign    <= w_sign;
            r_exp     <= w_exp_sum;
            r_mcand   <= {24'd0, 1'b1, x_frac_i};
            r_mplier  <= {1'b1, y_frac_i};
            r_acc     <= '0;
            r_cnt     <= '0;
            r_res_inv <= 1'b0;
            r_res_ovf <= 1'b0;
            r_res_unf <= 1'b0;
            if (w_nan) begin
              r_res_z   <= {w_sign, 31'h7fffffff};
              r_res_inv <= 1'b1;
              r_state   <= DONE;
            end else if (w_inf) begin
              r_res_z   <= {w_sign, 8'hff, 23'd0};
              r_state   <= DONE;
            end else if (w_zero) begin
              r_res_z   <= {w_sign, 31'd0};
              r_state   <= DONE;
            end else begin
              r_state   <= MULTIPLY;
            end
          end
        end
        MULTIPLY: begin
          // One multiplier bit per cycle; multiplicand walks left as multiplier walks right
          r_acc    <= r_acc + (r_mplier[0] ? r_mcand : 48'd0);
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 5'd1;
          if (r_cnt == 5'd23) begin
            r_state <= NORMALIZE;
          end
        end
        NORMALIZE: begin
          r_res_inv <= 1'b0;
          r_res_ovf <= w_ovf;
          r_res_unf <= w_unf;
          if (w_ovf) begin
            r_res_z <= {r_sign, 8'hff, 23'd0};
          end else if (w_unf) begin
            r_res_z <= {r_sign, 31'd0};
          end else begin
            r_res_z <= {r_sign, w_norm_exp[7:0], w_norm_frac};
          end
          r_state <= DONE;
        end
        DONE: begin
          r_z     <= r_res_z;
          r_inv   <= r_res_inv;
          r_ovf   <= r_res_ovf;
          r_unf   <= r_res_unf;
          r_valid <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data_valid_o               = r_valid;
  assign z_o                        = r_z;
  assign except_invalid_operation_o = r_inv;
  assign except_overflow_o          = r_ovf;
  assign except_underflow_o         = r_unf;

endmodule
